// File: rtl/pc_fetch_if.sv
// Fetch-control bus between pc_fetch (master) and the ROM/execute side (slave).
// PC_FETCH_INSTR_CNT_EN adds the instr_cnt observation signal.
interface pc_fetch_if #(
    parameter int PC_W = 16
);
    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            stall;
    logic [3:0]      opcode;
    logic [PC_W-1:0] jmp_loc;
    logic            branch_taken;
    logic [PC_W-1:0] pc;
    logic            running;
    logic            done;
`ifdef PC_FETCH_INSTR_CNT_EN
    logic [15:0]     instr_cnt;

    modport master (
        input  start, start_addr, stall, opcode, jmp_loc, branch_taken,
        output pc, running, done, instr_cnt
    );
    modport slave (
        output start, start_addr, stall, opcode, jmp_loc, branch_taken,
        input  pc, running, done, instr_cnt
    );
`else
    modport master (
        input  start, start_addr, stall, opcode, jmp_loc, branch_taken,
        output pc, running, done
    );
    modport slave (
        output start, start_addr, stall, opcode, jmp_loc, branch_taken,
        input  pc, running, done
    );
`endif
endinterface

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencing (IDLE/RUN/HALTED) with jump/branch redirect.
// Optional PC_FETCH_INSTR_CNT_EN: saturating count of issued (non-stalled, non-HALT) RUN cycles.
module pc_fetch #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_fetch_if.master    bus
);
    localparam logic [1:0]      ST_IDLE   = 2'b00;
    localparam logic [1:0]      ST_RUN    = 2'b01;
    localparam logic [1:0]      ST_HALTED = 2'b10;
    localparam logic [3:0]      OP_JMP    = 4'b0010;
    localparam logic [3:0]      OP_BNE    = 4'b1010;
    localparam logic [3:0]      OP_BEQ    = 4'b1011;
    localparam logic [3:0]      OP_BLT    = 4'b1100;
    localparam logic [3:0]      OP_HALT   = 4'b1110;
    localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, done_q;

    // Next-state and next-pc decision; an X opcode falls to the default (increment) arm
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (bus.start) begin
                    pc_d    = bus.start_addr;
                    state_d = ST_RUN;
                end else begin
                    pc_d    = pc_q;
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (bus.stall) begin
                    pc_d = pc_q;
                end else begin
                    case (bus.opcode)
                        OP_HALT: state_d = ST_HALTED;
                        OP_JMP:  pc_d    = bus.jmp_loc;
                        OP_BNE, OP_BEQ, OP_BLT: begin
                            if (bus.branch_taken) begin
                                pc_d = bus.jmp_loc;
                            end else begin
                                pc_d = pc_q + PC_ONE;
                            end
                        end
                        default: pc_d = pc_q + PC_ONE;
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // State, pc and status flags; flags follow the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_HALTED);
        end
    end

    assign bus.pc      = pc_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;

`ifdef PC_FETCH_INSTR_CNT_EN
    localparam logic [15:0] CNT_MAX = 16'hFFFF;
    logic [15:0] cnt_q, cnt_d;

    // Clear on accepted start, count issued RUN cycles, saturate at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_RUN) begin
            if (bus.start) begin
                cnt_d = 16'h0000;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (bus.stall) begin
            cnt_d = cnt_q;
        end else begin
            case (bus.opcode)
                OP_HALT: cnt_d = cnt_q;
                default: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 16'h0001;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            endcase
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.instr_cnt = cnt_q;
`endif
endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Program-counter and fetch-control stage sitting directly upstream of the instruction ROM/decoder.
- Owns the 16-bit `pc` fed to the ROM.
- Sequences run/halt and applies jump/branch redirects using the decoder's `jmpLoc` plus a taken-branch decision from execute.
- Raises `done` when a HALT instruction is fetched.

Parameters:
- PC_W, 16, width of program counter; matches ROM `pc` input.
- RESET_PC, 0, value loaded into `pc` on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begin execution at start_addr.
- start_addr  input  PC_W  program entry address, sampled when start is accepted.
- stall  input  1  hold pc and state this cycle (memory/execute busy).
- opcode  input  4  decoded opcode of the instruction at current pc (from ROM).
- jmp_loc  input  PC_W  redirect target from ROM `jmpLoc`.
- branch_taken  input  1  execute-stage decision for a BNE/BEQ/BLT at current pc.
- pc  output  PC_W  current fetch address to ROM.
- running  output  1  high while in RUN.
- done  output  1  high while in HALTED.

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, state=IDLE, running=0, done=0. Takes effect immediately, mid-operation included. First update after deassertion is on the next rising edge.
- Registered outputs: running=(state==RUN), done=(state==HALTED).
- States: IDLE, RUN, HALTED.

IDLE:
- pc held.
- start=1 -> pc<=start_addr, state<=RUN.
- All other inputs are ignored.

RUN (priority highest first):
- stall=1 -> pc and state held. Halt, jump and branch are all ignored this cycle.
- opcode==4'b1110 (HALT) -> state<=HALTED, pc held at the HALT address.
- opcode==4'b0010 (JMP) -> pc<=jmp_loc.
- opcode in {4'b1010, 4'b1011, 4'b1100} and branch_taken=1 -> pc<=jmp_loc.
- Otherwise -> pc<=pc+1, modulo 2^PC_W (0xFFFF wraps to 0x0000, no flag).
- branch_taken is ignored when opcode is not a branch.
- jmp_loc is sampled only on a redirect. X on jmp_loc is harmless otherwise.
- start in RUN is ignored; no restart.
- Unknown/X opcode (unprogrammed ROM address) is treated as a non-control instruction, so pc increments.

HALTED:
- pc held, done=1.
- start=1 -> pc<=start_addr, state<=RUN; done falls the following cycle.

Timing:
- Latency: every pc change appears one cycle after the deciding edge. The ROM is combinational, so opcode/jmp_loc for the new pc are valid within the same cycle.
- No delay slots: a redirect takes effect on the very next pc.
- Simultaneous events: HALT with branch_taken=1 gives HALTED, with no redirect.

Optional Feature:
- Macro: PC_FETCH_INSTR_CNT_EN.
- Defined:
  - Adds output `instr_cnt`, 16 bits.
  - Counts non-stalled RUN cycles, excluding the HALT cycle.
  - Reset to 0 by rst_n and on each accepted start.
  - Saturates at 0xFFFF.
  - Held in IDLE and HALTED.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset and entry: rst_n low mid-run -> pc=0, running=0, done=0 immediately. Then start=1 with start_addr=50 -> next cycle pc=50, running=1. Following cycles pc=51, 52, 53.
2. Jump: pc=60, opcode=0010, jmp_loc=10 -> next pc=10. Same opcode with stall=1 -> pc stays 60 until stall drops, then becomes 10.
3. Branch: pc=85, opcode=1011. With branch_taken=0 -> pc=86. With branch_taken=1, jmp_loc=118 -> pc=118. Opcode=0111 with branch_taken=1 -> pc=86.
4. Halt and restart: pc=127, opcode=1110 -> next cycle done=1, running=0, pc=127, held 5 cycles. Then start with start_addr=50 -> pc=50, running=1, done=0.
5. Wrap and ignore: start_addr=16'hFFFE, non-control opcodes -> pc goes FFFE, FFFF, 0000. A start pulse with start_addr=50 during RUN -> no effect.
6. With PC_FETCH_INSTR_CNT_EN: run 50..55 then HALT -> instr_cnt=6. Stalls do not count. A new start clears it to 0.
